// File: rtl/led_pkg.sv
// Shared types and constants for the 8x8 LED matrix row-scan controller.
package led_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int ROW_W       = 3;

  // One row of the display; bit 1 = LED on.
  typedef logic [MATRIX_COLS-1:0] row_t;

  // Row-slot phase: columns forced off (BLANK) or driven from the frame (SHOW).
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } phase_t;

  // Snapshot of the scan sequencer, handy for probing the phase FSM.
  typedef struct packed {
    phase_t           phase;
    logic [ROW_W-1:0] scan;
    logic             boundary;
    logic             swap_take;
  } scan_dbg_t;

  // Row index advance; 7 wraps back to 0.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return r + ROW_W'(1);
  endfunction

endpackage

// File: rtl/led_frame_buf.sv
// Double-buffered 8x8 frame store: writes go to the back bank, the scan
// reads the front bank, and a toggle exchanges the roles of the two banks.
module led_frame_buf
  import led_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  row_t             wr_data,
  input  logic             toggle,
  input  logic [ROW_W-1:0] rd_row,
  output row_t             rd_data,
  output logic             front_sel
);

  row_t bank0 [MATRIX_ROWS];
  row_t bank1 [MATRIX_ROWS];
  logic sel;

  // Bank storage and front select. A write in the same edge as a toggle
  // lands in the current back bank, which becomes the new front.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MATRIX_ROWS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      sel <= 1'b0;
    end else begin
      if (wr_en) begin
        if (sel) bank0[wr_row] <= wr_data;
        else     bank1[wr_row] <= wr_data;
      end
      if (toggle) sel <= ~sel;
    end
  end

  // Asynchronous read of the front bank.
  always_comb begin
    rd_data = sel ? bank1[rd_row] : bank0[rd_row];
  end

  assign front_sel = sel;

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan sequencer for the 8x8 LED matrix: steps the row index once per
// slot, blanks the columns at the start of every slot, and applies buffer
// swaps only at the frame boundary so a frame is never torn.
module led_matrix_scan_ctrl
  import led_pkg::*;
#(
  parameter int CLK_DIV   = 1024,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  row_t             wr_data,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic [ROW_W-1:0] scan,
  output row_t             col,
  output logic             frame_start
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ROW_W-1:0] scan_q, scan_n;
  phase_t           phase, phase_n;
  row_t             col_q, col_n;
  logic             ack_q, fs_q;
  logic             cnt_wrap;
  logic             boundary;
  logic             swap_take;
  row_t             front_row;
  logic             front_sel;
  scan_dbg_t        dbg;

  // Handshake: swap_req is a level; it is only looked at on the frame
  // boundary edge (scan 7 -> 0). When taken, swap_ack pulses for one cycle
  // together with frame_start. The requester drops swap_req after swap_ack.

  led_frame_buf u_frame_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .toggle    (swap_take),
    .rd_row    (scan_n),
    .rd_data   (front_row),
    .front_sel (front_sel)
  );

  // Next-state logic: slot counter, row index, phase and column pattern.
  // The column register is loaded from the state it will hold after the
  // edge, so blanking always coincides with (or precedes) a row change.
  always_comb begin
    cnt_wrap  = 1'b0;
    cnt_n     = cnt;
    scan_n    = scan_q;
    boundary  = 1'b0;
    swap_take = 1'b0;
    phase_n   = phase;
    col_n     = '0;

    cnt_wrap  = (cnt == CNT_MAX);
    cnt_n     = cnt_wrap ? '0 : cnt + CNT_W'(1);
    scan_n    = cnt_wrap ? next_row(scan_q) : scan_q;
    boundary  = cnt_wrap && (scan_q == ROW_W'(MATRIX_ROWS - 1));
    swap_take = boundary && swap_req;

    case (phase)
      BLANK:   phase_n = (cnt_n >= BLANK_V) ? SHOW : BLANK;
      SHOW:    phase_n = cnt_wrap ? BLANK : SHOW;
      default: phase_n = BLANK;
    endcase

    col_n = (phase_n == SHOW) ? front_row : '0;
  end

  // Phase state register.
  always_ff @(posedge clk) begin
    if (rst) phase <= BLANK;
    else     phase <= phase_n;
  end

  // Counter, row index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      scan_q <= '0;
      col_q  <= '0;
      ack_q  <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      scan_q <= scan_n;
      col_q  <= col_n;
      ack_q  <= swap_take;
      fs_q   <= boundary;
    end
  end

  // Debug snapshot of the sequencer state.
  always_comb begin
    dbg           = '0;
    dbg.phase     = phase;
    dbg.scan      = scan_q;
    dbg.boundary  = boundary;
    dbg.swap_take = swap_take ^ (front_sel & 1'b0);
  end

  assign scan        = scan_q;
  assign col         = col_q;
  assign swap_ack    = ack_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl: directed scenarios plus random writes and
// swaps, checked every cycle against a frame-level behavioural model.
module tb_led_matrix_scan_ctrl;

  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 8 * CLK_DIV;

  // Clock/reset block
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic [2:0] scan;
  logic [7:0] col;
  logic       frame_start;

  always #5 clk = ~clk;

  led_matrix_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .scan        (scan),
    .col         (col),
    .frame_start (frame_start)
  );

  // Scoreboard
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: time since reset decides row and phase; swap exchanges
  // the contents of two plain arrays.
  int         cyc = 0;
  logic [7:0] fm [8];
  logic [7:0] bm [8];
  logic [2:0] prev_scan = 3'd0;
  int         since_change = 100;
  int         ack_count = 0;

  task automatic tick();
    logic       bnd;
    logic       exp_ack;
    logic [7:0] tmp;
    int         exp_scan;
    int         exp_cnt;
    @(posedge clk);
    exp_ack = 1'b0;
    bnd     = 1'b0;
    if (rst) begin
      cyc = 0;
      for (int i = 0; i < 8; i++) begin
        fm[i] = 8'h00;
        bm[i] = 8'h00;
      end
    end else begin
      if (wr_en) bm[wr_row] = wr_data;
      bnd = ((cyc + 1) % FRAME) == 0;
      if (bnd && swap_req) begin
        exp_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
          tmp   = fm[i];
          fm[i] = bm[i];
          bm[i] = tmp;
        end
      end
      cyc++;
    end
    exp_scan = (cyc / CLK_DIV) % 8;
    exp_cnt  = cyc % CLK_DIV;
    exp_q.push_back((exp_cnt >= BLANK_CYC) ? fm[exp_scan] : 8'h00);
    #1;
    check_val("scan", 32'(scan), 32'(exp_scan));
    check_val("col", 32'(col), 32'(exp_q.pop_front()));
    check_val("swap_ack", 32'(swap_ack), 32'(exp_ack));
    check_val("frame_start", 32'(frame_start), 32'(bnd));
    if (swap_ack) ack_count++;
    // Ghosting: a row change never shows a lit column in its first slots.
    if (scan != prev_scan) since_change = 0;
    else if (since_change < 100) since_change++;
    if (since_change < BLANK_CYC) check_val("ghost", 32'(col), 32'h0);
    prev_scan = scan;
  endtask

  // Driver tasks
  task automatic write_row(input logic [2:0] r, input logic [7:0] d);
    wr_en = 1'b1; wr_row = r; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic swap_and_wait(input string tag);
    logic seen;
    seen = 1'b0;
    swap_req = 1'b1;
    for (int i = 0; i < FRAME + 2 && !seen; i++) begin
      tick();
      if (swap_ack) seen = 1'b1;
    end
    swap_req = 1'b0;
    check_val(tag, 32'(seen), 32'h1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0;

    // Reset held 3 cycles, then one idle frame of blank columns.
    run(3);
    check_val("rst_scan", 32'(scan), 32'h0);
    check_val("rst_col", 32'(col), 32'h0);
    rst = 1'b0;
    run(FRAME);

    // Walking-one pattern, swap, three frames of display.
    for (int r = 0; r < 8; r++) write_row(3'(r), 8'h01 << r);
    swap_and_wait("swap1_ack");
    run(3 * FRAME);

    // Write to row 0 in the very cycle of the swap edge.
    swap_req = 1'b1;
    for (int i = 0; i < FRAME && ((cyc + 1) % FRAME) != 0; i++) tick();
    write_row(3'd0, 8'hA5);
    check_val("edge_swap_ack", 32'(swap_ack), 32'h1);
    swap_req = 1'b0;
    run(BLANK_CYC);
    check_val("edge_write_col", 32'(col), 32'hA5);
    run(FRAME);

    // Back-buffer writes without a swap leave the display untouched.
    for (int r = 0; r < 8; r++) write_row(3'(r), 8'hFF);
    run(4 * FRAME);

    // Random writes and swap requests.
    for (int i = 0; i < 1500; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_row  = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) swap_req = ~swap_req;
      tick();
    end
    wr_en = 1'b0;
    swap_req = 1'b0;

    // Reset mid-frame at scan=5, cnt=4 with a swap pending.
    for (int i = 0; i < FRAME && (cyc % FRAME) != (5 * CLK_DIV + 4); i++) tick();
    check_val("pre_rst_scan", 32'(scan), 32'h5);
    ack_count = 0;
    swap_req = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    swap_req = 1'b0;
    check_val("midrst_scan", 32'(scan), 32'h0);
    check_val("midrst_col", 32'(col), 32'h0);
    run(2 * FRAME);
    check_val("dropped_swap_acks", 32'(ack_count), 32'h0);

    // Both banks were cleared: swapping in the back bank still shows nothing.
    swap_and_wait("swap_after_rst_ack");
    run(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
